// File: rtl/coeff_bank.sv
// coeff_bank: multi-port coefficient store with a streamed valid/ready load port.
// Optional COEFF_BANK_CHECKSUM_EN adds a load_checksum output (sum of loaded words).
module coeff_bank #(
  parameter int DEPTH    = 24,
  parameter int WORDS    = 5,
  parameter int CHANNELS = 2,
  localparam int AW      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic                      load_valid,
  input  logic [DEPTH-1:0]          load_data,
  output logic                      load_ready,
  output logic                      load_done,
  output logic                      busy,
  input  logic [CHANNELS-1:0]       rd_en,
  input  logic [CHANNELS*AW-1:0]    rd_addr,
  output logic [CHANNELS*DEPTH-1:0] rd_data,
  output logic [CHANNELS-1:0]       rd_valid,
  output logic                      err_conflict,
  output logic                      err_range,
  output logic [1:0]                fsm_state
`ifdef COEFF_BANK_CHECKSUM_EN
  ,
  output logic [DEPTH-1:0]          load_checksum
`endif
);

  // Load handshake: a word transfers on a rising clk edge where load_valid and
  // load_ready are both high; load_ready is high exactly while in LOAD.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [AW-1:0]     ptr;
  logic [DEPTH-1:0]  mem [WORDS];

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
`ifdef COEFF_BANK_CHECKSUM_EN
      load_checksum <= '0;
`endif
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
`ifdef COEFF_BANK_CHECKSUM_EN
            load_checksum <= '0;
`endif
          end
        end
        LOAD: begin
          if (load_valid && load_ready) begin
            mem[ptr] <= load_data;
            ptr      <= ptr + AW'(1);
`ifdef COEFF_BANK_CHECKSUM_EN
            load_checksum <= load_checksum + load_data;
`endif
            if (ptr == AW'(WORDS - 1)) begin
              state      <= DONE;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Read ports: busy is the registered FSM flag, so a read in DONE still conflicts.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data      <= '0;
      rd_valid     <= '0;
      err_conflict <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (rd_en[c]) begin
          if (busy) begin
            rd_data[c*DEPTH +: DEPTH] <= '0;
            rd_valid[c]               <= 1'b0;
            err_conflict              <= 1'b1;
          end else if (32'(rd_addr[c*AW +: AW]) < WORDS) begin
            rd_data[c*DEPTH +: DEPTH] <= mem[rd_addr[c*AW +: AW]];
            rd_valid[c]               <= 1'b1;
          end else begin
            rd_data[c*DEPTH +: DEPTH] <= '0;
            rd_valid[c]               <= 1'b1;
            err_range                 <= 1'b1;
          end
        end else begin
          rd_valid[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_coeff_bank.sv
// Self-checking bench for coeff_bank (DEPTH=24, WORDS=5, CHANNELS=2).
// Build with +define+COEFF_BANK_CHECKSUM_EN to also cover load_checksum.
module tb_coeff_bank;
  localparam int DEPTH = 24;
  localparam int WORDS = 5;
  localparam int CH    = 2;
  localparam int AW    = 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                  load_start, load_valid, load_ready, load_done, busy;
  logic [DEPTH-1:0]      load_data;
  logic [CH-1:0]         rd_en, rd_valid;
  logic [CH*AW-1:0]      rd_addr;
  logic [CH*DEPTH-1:0]   rd_data;
  logic                  err_conflict, err_range;
  logic [1:0]            fsm_state;
`ifdef COEFF_BANK_CHECKSUM_EN
  logic [DEPTH-1:0]      load_checksum;
`endif

  coeff_bank #(.DEPTH(DEPTH), .WORDS(WORDS), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .err_conflict(err_conflict), .err_range(err_range), .fsm_state(fsm_state)
`ifdef COEFF_BANK_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  // scoreboard state
  logic [DEPTH:0]   exp_q[$];
  logic [DEPTH-1:0] model [WORDS];
  logic [DEPTH-1:0] vals  [WORDS];
  logic [DEPTH-1:0] last_data [CH];
  logic             exp_conflict, exp_range;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < WORDS; i++) model[i] = '0;
    for (int c = 0; c < CH; c++) last_data[c] = '0;
    exp_conflict = 1'b0;
    exp_range    = 1'b0;
  endtask

  // One read cycle on both channels; the caller is at a negedge with the bank idle.
  task automatic do_read(input logic [CH-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [AW-1:0]  a [CH];
    logic [DEPTH:0] e;
    a[0] = a0;
    a[1] = a1;
    rd_en   = en;
    rd_addr = {a1, a0};
    for (int c = 0; c < CH; c++) begin
      if (!en[c]) e = {1'b0, last_data[c]};
      else if (int'(a[c]) < WORDS) e = {1'b1, model[a[c]]};
      else begin
        e = {1'b1, {DEPTH{1'b0}}};
        exp_range = 1'b1;
      end
      last_data[c] = e[DEPTH-1:0];
      exp_q.push_back(e);
    end
    @(negedge clk);
    rd_en = '0;
    for (int c = 0; c < CH; c++) begin
      e = exp_q.pop_front();
      check($sformatf("rd_valid%0d", c), 64'(rd_valid[c]), 64'(e[DEPTH]));
      check($sformatf("rd_data%0d", c), 64'(rd_data[c*DEPTH +: DEPTH]), 64'(e[DEPTH-1:0]));
    end
    check("err_conflict", 64'(err_conflict), 64'(exp_conflict));
    check("err_range", 64'(err_range), 64'(exp_range));
  endtask

  // Full load of vals[]; gappy drops load_valid on even cycles; conflict_rd issues a
  // ch0 read of addr 3 at cycle 2 of the load. Cycle 0 is the load_start cycle.
  task automatic do_load(input bit gappy, input bit conflict_rd);
    int cyc = 1;
    int n = 0;
    bit seen = 0;
    int done_cycle = -1;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    while (!seen && cyc < 40) begin
      if (load_done) begin
        seen = 1;
        done_cycle = cyc;
      end else begin
        if (cyc == 2) check("busy_in_load", 64'(busy), 64'(1));
        if (conflict_rd && cyc == 2) begin
          rd_en   = 2'b01;
          rd_addr = {3'd0, 3'd3};
        end
        if (conflict_rd && cyc == 3) begin
          rd_en = '0;
          exp_conflict = 1'b1;
          last_data[0] = '0;
          check("conflict_valid", 64'(rd_valid[0]), 64'(0));
          check("conflict_data", 64'(rd_data[DEPTH-1:0]), 64'(0));
          check("conflict_flag", 64'(err_conflict), 64'(1));
        end
        load_valid = (n < WORDS) && (!gappy || cyc[0]);
        load_data  = vals[n < WORDS ? n : 0];
        if (load_valid && load_ready) begin
          model[n] = vals[n];
          n++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    load_valid = 1'b0;
    check("load_done_seen", 64'(seen), 64'(1));
    check("load_words", 64'(n), 64'(WORDS));
    check("load_done_cycle", 64'(done_cycle), gappy ? 64'(2*WORDS) : 64'(WORDS+1));
`ifdef COEFF_BANK_CHECKSUM_EN
    begin
      logic [DEPTH-1:0] sum = '0;
      for (int i = 0; i < WORDS; i++) sum += vals[i];
      check("checksum", 64'(load_checksum), 64'(sum));
    end
`endif
    check("busy_at_done", 64'(busy), 64'(1));
    @(negedge clk);
    check("load_done_pulse", 64'(load_done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("state_idle", 64'(fsm_state), 64'(0));
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    rd_en = '0; rd_addr = '0;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(load_ready), 64'(0));
    check("rst_done", 64'(load_done), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_errs", 64'({err_conflict, err_range}), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(0));

    // back-to-back load, then parallel read of addr 2 / 4
    for (int i = 0; i < WORDS; i++) vals[i] = DEPTH'((i + 1) * 'h11);
    do_load(1'b0, 1'b0);
    do_read(2'b11, 3'd2, 3'd4);

    // out-of-range read on ch1, then same address on both channels
    do_read(2'b10, 3'd0, 3'd6);
    do_read(2'b11, 3'd1, 3'd1);

    // gappy reload with new data plus a conflicting read during LOAD
    for (int i = 0; i < WORDS; i++) vals[i] = DEPTH'($urandom_range(0, 'hFFFFFF));
    do_load(1'b1, 1'b1);
    for (int i = 0; i < WORDS; i++) do_read(2'b01, AW'(i), 3'd0);
    for (int i = 0; i < 20; i++)
      do_read(CH'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));

`ifdef COEFF_BANK_CHECKSUM_EN
    vals[0] = 24'hFFFFFF; vals[1] = 24'h000002; vals[2] = '0; vals[3] = '0; vals[4] = '0;
    do_load(1'b0, 1'b0);
    check("checksum_wrap", 64'(load_checksum), 64'(24'h000001));
`endif

    // reset after 3 accepted words; load_start pulsed during LOAD must be ignored
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 24'hABCDEF;
    repeat (3) @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_state", 64'(fsm_state), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", 64'(load_done), 64'(0));
      @(negedge clk);
    end
    for (int i = 0; i < WORDS; i++) do_read(2'b11, AW'(i), AW'(WORDS - 1 - i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
